rtc_write_sequencer: RTL and testbench

Generates the RTC multiplexed-bus write sequence: an address phase (a_d_l low) followed by a data phase (a_d_l high). In each phase the bus drives the value and cs_l/wr_l are pulsed. This is the write-side counterpart of the RTC read-control block. The FSM issues start with addr/data and waits for done. Only one of read or write control drives the RTC pins at a time; top-level muxing selects which.

---
 rtl/rtc_bus_pkg.sv | 29 ++
 rtl/rtc_phase_timer.sv | 29 ++
 rtl/rtc_write_sequencer.sv | 141 ++++++++++++++
 tb/tb_rtc_write_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus sequencers.
// Contents: bus and counter widths, default phase timings, a_d_l phase encoding,
// and the write sequencer state enum.
package rtc_bus_pkg;

  localparam int unsigned RTC_DW = 8;
  localparam int unsigned RTC_CW = 8;

  localparam int unsigned T_SETUP_DEF = 2;
  localparam int unsigned T_PULSE_DEF = 6;
  localparam int unsigned T_HOLD_DEF  = 2;
  localparam int unsigned T_GAP_DEF   = 10;

  localparam logic A_D_ADDR = 1'b0;
  localparam logic A_D_DATA = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_PULSE,
    ST_A_HOLD,
    ST_GAP,
    ST_D_SETUP,
    ST_D_PULSE,
    ST_D_HOLD,
    ST_DONE
  } wr_state_e;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that times one bus phase.
// Ports: clk, rst (sync, active-high); load/load_value reload the count;
// expire_c is high while the count is zero (last cycle of the phase).
module rtc_phase_timer
  import rtc_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [RTC_CW-1:0] load_value,
  output logic              expire_c
);

  logic [RTC_CW-1:0] count;

  // Counter holds at zero until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - RTC_CW'(1);
    end
  end

  assign expire_c = (count == '0);

endmodule

// File: rtl/rtc_write_sequencer.sv
// RTC multiplexed-bus write sequencer: address phase (a_d_l=0) then data phase
// (a_d_l=1), each with setup / wr_l pulse / hold, separated by a released-bus gap.
// Ports: clk, rst (sync, active-high); start/addr/data request a write;
// cs_l, rd_l, wr_l, a_d_l, bus_out, bus_oe drive the RTC pins; busy, done status.
module rtc_write_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_PULSE = T_PULSE_DEF,
  parameter int unsigned T_HOLD  = T_HOLD_DEF,
  parameter int unsigned T_GAP   = T_GAP_DEF,
  parameter int unsigned DW      = RTC_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic          cs_l,
  output logic          rd_l,
  output logic          wr_l,
  output logic          a_d_l,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  output logic          busy,
  output logic          done
);

  // A phase of N cycles loads N-1 so the timer expires in its last cycle.
  localparam logic [RTC_CW-1:0] LD_SETUP = RTC_CW'(T_SETUP - 1);
  localparam logic [RTC_CW-1:0] LD_PULSE = RTC_CW'(T_PULSE - 1);
  localparam logic [RTC_CW-1:0] LD_HOLD  = RTC_CW'(T_HOLD - 1);
  localparam logic [RTC_CW-1:0] LD_GAP   = RTC_CW'(T_GAP - 1);

  wr_state_e         state, state_next;
  logic              load, expire_c;
  logic [RTC_CW-1:0] load_value;
  logic [DW-1:0]     addr_q, data_q, addr_src;
  logic              cs_d, wr_d, a_d_d, oe_d, busy_d, done_d;
  logic [DW-1:0]     bus_d;

  rtc_phase_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_value (load_value),
    .expire_c   (expire_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // On the accepting edge the latch is not yet loaded, so take addr directly.
  assign addr_src = (state == ST_IDLE) ? addr : addr_q;

  // Next state, timer control, and output values for the state being entered.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_value = '0;
    cs_d       = 1'b1;
    wr_d       = 1'b1;
    a_d_d      = A_D_DATA;
    oe_d       = 1'b0;
    bus_d      = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state)
      ST_IDLE:    if (start)    begin state_next = ST_A_SETUP; load = 1'b1; load_value = LD_SETUP; end
      ST_A_SETUP: if (expire_c) begin state_next = ST_A_PULSE; load = 1'b1; load_value = LD_PULSE; end
      ST_A_PULSE: if (expire_c) begin state_next = ST_A_HOLD;  load = 1'b1; load_value = LD_HOLD;  end
      ST_A_HOLD:  if (expire_c) begin state_next = ST_GAP;     load = 1'b1; load_value = LD_GAP;   end
      ST_GAP:     if (expire_c) begin state_next = ST_D_SETUP; load = 1'b1; load_value = LD_SETUP; end
      ST_D_SETUP: if (expire_c) begin state_next = ST_D_PULSE; load = 1'b1; load_value = LD_PULSE; end
      ST_D_PULSE: if (expire_c) begin state_next = ST_D_HOLD;  load = 1'b1; load_value = LD_HOLD;  end
      ST_D_HOLD:  if (expire_c) state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase

    case (state_next)
      ST_A_SETUP, ST_A_HOLD, ST_A_PULSE: begin
        cs_d   = 1'b0;
        wr_d   = (state_next != ST_A_PULSE);
        a_d_d  = A_D_ADDR;
        oe_d   = 1'b1;
        bus_d  = addr_src;
        busy_d = 1'b1;
      end
      ST_D_SETUP, ST_D_HOLD, ST_D_PULSE: begin
        cs_d   = 1'b0;
        wr_d   = (state_next != ST_D_PULSE);
        oe_d   = 1'b1;
        bus_d  = data_q;
        busy_d = 1'b1;
      end
      ST_GAP:  busy_d = 1'b1;
      ST_DONE: begin busy_d = 1'b1; done_d = 1'b1; end
      default: ;
    endcase
  end

  // Request latches, loaded only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (state == ST_IDLE && start) begin
      addr_q <= addr;
      data_q <= data;
    end
  end

  // Registered pin and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_l    <= 1'b1;
      rd_l    <= 1'b1;
      wr_l    <= 1'b1;
      a_d_l   <= 1'b1;
      bus_oe  <= 1'b0;
      bus_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      cs_l    <= cs_d;
      rd_l    <= 1'b1;
      wr_l    <= wr_d;
      a_d_l   <= a_d_d;
      bus_oe  <= oe_d;
      bus_out <= bus_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Testbench for rtc_write_sequencer: default-timing instance and an all-ones
// timing instance, checked cycle by cycle against hand-written phase tables.
module tb_rtc_write_sequencer;

  typedef struct {
    int   lo;
    int   hi;
    logic cs_l;
    logic wr_l;
    logic a_d_l;
    logic bus_oe;
    int   sel;   // 0 = zero, 1 = address, 2 = data
    logic busy;
    logic done;
  } seg_t;

  // Observation vector: {cs_l, rd_l, wr_l, a_d_l, bus_oe, busy, done, bus_out}
  localparam logic [14:0] IDLE_VEC = 15'h7800;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_q = 1'b1;
  logic       start = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data = 8'h00;

  logic       cs_l0, rd_l0, wr_l0, a_d_l0, bus_oe0, busy0, done0;
  logic [7:0] bus_out0;
  logic       cs_l1, rd_l1, wr_l1, a_d_l1, bus_oe1, busy1, done1;
  logic [7:0] bus_out1;
  logic [14:0] obs0, obs1, prev0, prev1;

  int checks = 0;
  int failures = 0;
  bit inv_on = 1'b0;

  seg_t tbl_def[8];
  seg_t tbl_fast[8];

  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst;

  rtc_write_sequencer dut0 (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .data(data),
    .cs_l(cs_l0), .rd_l(rd_l0), .wr_l(wr_l0), .a_d_l(a_d_l0),
    .bus_out(bus_out0), .bus_oe(bus_oe0), .busy(busy0), .done(done0)
  );

  rtc_write_sequencer #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .data(data),
    .cs_l(cs_l1), .rd_l(rd_l1), .wr_l(wr_l1), .a_d_l(a_d_l1),
    .bus_out(bus_out1), .bus_oe(bus_oe1), .busy(busy1), .done(done1)
  );

  assign obs0 = {cs_l0, rd_l0, wr_l0, a_d_l0, bus_oe0, busy0, done0, bus_out0};
  assign obs1 = {cs_l1, rd_l1, wr_l1, a_d_l1, bus_oe1, busy1, done1, bus_out1};

  function automatic seg_t mk(int lo, int hi, logic cs, logic wr, logic ad, logic oe,
                              int sel, logic bsy, logic dn);
    seg_t s;
    s.lo = lo; s.hi = hi; s.cs_l = cs; s.wr_l = wr; s.a_d_l = ad; s.bus_oe = oe;
    s.sel = sel; s.busy = bsy; s.done = dn;
    return s;
  endfunction

  function automatic logic [14:0] exp_vec(int which, int k, logic [7:0] a, logic [7:0] d);
    logic [14:0] r;
    seg_t s;
    r = IDLE_VEC;
    for (int i = 0; i < 8; i++) begin
      s = (which == 0) ? tbl_def[i] : tbl_fast[i];
      if (k >= s.lo && k <= s.hi)
        r = {s.cs_l, 1'b1, s.wr_l, s.a_d_l, s.bus_oe, s.busy, s.done,
             (s.sel == 1) ? a : ((s.sel == 2) ? d : 8'h00)};
    end
    return r;
  endfunction

  function automatic logic [14:0] sel_obs(int which);
    return (which == 0) ? obs0 : obs1;
  endfunction

  task automatic check(input string nm, input logic [14:0] act, input logic [14:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", nm, act, req);
    end
  endtask

  // Invariants on one instance; edge rule skipped on the cycle after a reset edge.
  task automatic inv(input string nm, input logic [14:0] o, input logic [14:0] p);
    checks++;
    if (o[13] !== 1'b1) begin
      failures++;
      $display("FAIL %s rd_l got=%b required=1", nm, o[13]);
    end
    if (o[12] === 1'b0) begin
      checks++;
      if (o[14] !== 1'b0 || o[10] !== 1'b1) begin
        failures++;
        $display("FAIL %s wr_l low: cs_l=%b bus_oe=%b required cs_l=0 bus_oe=1", nm, o[14], o[10]);
      end
    end
    if (!rst_q && o[12] !== p[12]) begin
      checks++;
      if (o[10] !== p[10]) begin
        failures++;
        $display("FAIL %s bus_oe changed with wr_l edge: bus_oe %b->%b", nm, p[10], o[10]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (inv_on) begin
      inv("inv_dut0", obs0, prev0);
      inv("inv_dut1", obs1, prev1);
    end
    prev0 = obs0;
    prev1 = obs1;
  end

  task automatic idle_cycles(input int which, input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst = 1'b0;
      check($sformatf("%s_c%0d", nm, i), sel_obs(which), IDLE_VEC);
    end
  endtask

  // One write; samples cycles E+1..end. Ends inside the DONE cycle (or abort cycle).
  task automatic run_seq(input int which, input logic [7:0] a, input logic [7:0] d,
                         input bit inject, input int abort_at, input string nm);
    int pulses;
    int last;
    logic prev_wr;
    logic [14:0] o;
    last = (which == 0) ? 31 : 8;
    @(posedge clk); #1;
    check({nm, "_idle"}, sel_obs(which), IDLE_VEC);
    start = 1'b1; addr = a; data = d;
    @(posedge clk); #1;
    start = 1'b0; addr = ~a; data = ~d;
    pulses = 0;
    prev_wr = 1'b1;
    for (int k = 1; k <= last; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (inject && k == 11) begin start = 1'b0; addr = ~a; data = ~d; end
      o = sel_obs(which);
      check($sformatf("%s_E+%0d", nm, k), o, exp_vec(which, k, a, d));
      if (prev_wr && !o[12]) pulses++;
      prev_wr = o[12];
      if (k == abort_at) begin
        rst = 1'b1;
        break;
      end
      if (inject && (k == 10 || k == last)) begin
        start = 1'b1; addr = 8'h99; data = 8'h99;
      end
    end
    if (abort_at == 0) begin
      checks++;
      if (pulses != 2) begin
        failures++;
        $display("FAIL %s_wr_pulses got=%0d required=2", nm, pulses);
      end
    end
  endtask

  initial begin
    tbl_def[0] = mk( 1,  2, 0, 1, 0, 1, 1, 1, 0);
    tbl_def[1] = mk( 3,  8, 0, 0, 0, 1, 1, 1, 0);
    tbl_def[2] = mk( 9, 10, 0, 1, 0, 1, 1, 1, 0);
    tbl_def[3] = mk(11, 20, 1, 1, 1, 0, 0, 1, 0);
    tbl_def[4] = mk(21, 22, 0, 1, 1, 1, 2, 1, 0);
    tbl_def[5] = mk(23, 28, 0, 0, 1, 1, 2, 1, 0);
    tbl_def[6] = mk(29, 30, 0, 1, 1, 1, 2, 1, 0);
    tbl_def[7] = mk(31, 31, 1, 1, 1, 0, 0, 1, 1);
    tbl_fast[0] = mk(1, 1, 0, 1, 0, 1, 1, 1, 0);
    tbl_fast[1] = mk(2, 2, 0, 0, 0, 1, 1, 1, 0);
    tbl_fast[2] = mk(3, 3, 0, 1, 0, 1, 1, 1, 0);
    tbl_fast[3] = mk(4, 4, 1, 1, 1, 0, 0, 1, 0);
    tbl_fast[4] = mk(5, 5, 0, 1, 1, 1, 2, 1, 0);
    tbl_fast[5] = mk(6, 6, 0, 0, 1, 1, 2, 1, 0);
    tbl_fast[6] = mk(7, 7, 0, 1, 1, 1, 2, 1, 0);
    tbl_fast[7] = mk(8, 8, 1, 1, 1, 0, 0, 1, 1);

    // Reset held for 3 cycles, then idle.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("reset_c%0d", i), obs0, IDLE_VEC);
    end
    rst = 1'b0;
    inv_on = 1'b1;
    idle_cycles(0, 3, "idle");

    // Single write with ignored starts at E+10 and in DONE.
    run_seq(0, 8'h21, 8'h45, 1'b1, 0, "single");
    idle_cycles(0, 3, "after_done");

    // Back-to-back: second start in the first IDLE cycle after DONE.
    run_seq(0, 8'h5A, 8'hC3, 1'b0, 0, "b2b_first");
    run_seq(0, 8'h22, 8'h00, 1'b0, 0, "b2b_second");

    // Reset during the address wr_l pulse.
    run_seq(0, 8'h33, 8'h44, 1'b0, 5, "abort");
    idle_cycles(0, 35, "abort_idle");
    run_seq(0, 8'hA7, 8'h7A, 1'b0, 0, "after_abort");

    // Minimum timings on the second instance.
    idle_cycles(1, 40, "fast_pre");
    run_seq(1, 8'h3C, 8'hA5, 1'b0, 0, "fast_first");
    run_seq(1, 8'hF0, 8'h0F, 1'b0, 0, "fast_second");
    idle_cycles(1, 3, "fast_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
